// File: rtl/vram_blitter.sv
// vram_blitter: FILL/COPY engine sharing the video RAM CPU port, CPU has priority.
// Define VRAM_BLIT_COPY_EN to build the COPY path; without it COPY completes as len=0.
module vram_blitter (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_chip_select_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_write_data_i,
  input  logic [3:0]  cpu_write_mask_i,
  output logic [31:0] cpu_read_data_o,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_op_i,
  input  logic [11:0] cmd_src_i,
  input  logic [11:0] cmd_dst_i,
  input  logic [12:0] cmd_len_i,
  input  logic [31:0] cmd_fill_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ram_chip_select_o,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_write_data_o,
  output logic [3:0]  ram_write_mask_o,
  input  logic [31:0] ram_read_data_i
);

`ifdef VRAM_BLIT_COPY_EN
  typedef enum logic [2:0] {
    IDLE, FILL, COPY_RD, COPY_CAP, COPY_WR
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, FILL
  } state_t;
`endif

  state_t      state_q, state_n;
  logic [11:0] dst_q, dst_n;
  logic [12:0] cnt_q, cnt_n;
  logic [31:0] fill_q, fill_n;
  logic        done_q, done_n;

`ifdef VRAM_BLIT_COPY_EN
  logic [11:0] src_q, src_n;
  logic [31:0] hold_q, hold_n;
`else
  logic        unused_src;
  assign unused_src = ^cmd_src_i;
`endif

  logic        blit_cs;
  logic [3:0]  blit_mask;
  logic [11:0] blit_idx;
  logic [31:0] blit_wdata;
  logic        cpu_busy;

  assign cpu_busy = cpu_chip_select_i;

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      dst_q   <= '0;
      cnt_q   <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
`ifdef VRAM_BLIT_COPY_EN
      src_q   <= '0;
      hold_q  <= '0;
`endif
    end else begin
      state_q <= state_n;
      dst_q   <= dst_n;
      cnt_q   <= cnt_n;
      fill_q  <= fill_n;
      done_q  <= done_n;
`ifdef VRAM_BLIT_COPY_EN
      src_q   <= src_n;
      hold_q  <= hold_n;
`endif
    end
  end

  // Next-state logic and blitter port request; any CPU access stalls it.
  always_comb begin
    state_n    = state_q;
    dst_n      = dst_q;
    cnt_n      = cnt_q;
    fill_n     = fill_q;
    done_n     = 1'b0;
    blit_cs    = 1'b0;
    blit_mask  = 4'h0;
    blit_idx   = dst_q;
    blit_wdata = fill_q;
`ifdef VRAM_BLIT_COPY_EN
    src_n      = src_q;
    hold_n     = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_len_i == '0) begin
            done_n = 1'b1;
          end else if (!cmd_op_i) begin
            dst_n   = cmd_dst_i;
            cnt_n   = cmd_len_i;
            fill_n  = cmd_fill_i;
            state_n = FILL;
          end else begin
`ifdef VRAM_BLIT_COPY_EN
            src_n   = cmd_src_i;
            dst_n   = cmd_dst_i;
            cnt_n   = cmd_len_i;
            state_n = COPY_RD;
`else
            done_n  = 1'b1;
`endif
          end
        end
      end
      FILL: begin
        if (!cpu_busy) begin
          blit_cs   = 1'b1;
          blit_mask = 4'hF;
          dst_n     = dst_q + 12'd1;
          cnt_n     = cnt_q - 13'd1;
          if (cnt_q == 13'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
      end
`ifdef VRAM_BLIT_COPY_EN
      COPY_RD: begin
        blit_idx = src_q;
        if (!cpu_busy) begin
          blit_cs = 1'b1;
          state_n = COPY_CAP;
        end
      end
      COPY_CAP: begin
        hold_n  = ram_read_data_i;
        state_n = COPY_WR;
      end
      COPY_WR: begin
        blit_wdata = hold_q;
        if (!cpu_busy) begin
          blit_cs   = 1'b1;
          blit_mask = 4'hF;
          src_n     = src_q + 12'd1;
          dst_n     = dst_q + 12'd1;
          cnt_n     = cnt_q - 13'd1;
          if (cnt_q == 13'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = COPY_RD;
          end
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end

  // RAM port mux: CPU passes straight through, otherwise blitter or idle.
  always_comb begin
    if (cpu_busy) begin
      ram_chip_select_o = 1'b1;
      ram_addr_o        = cpu_addr_i;
      ram_write_data_o  = cpu_write_data_i;
      ram_write_mask_o  = cpu_write_mask_i;
    end else begin
      ram_chip_select_o = blit_cs;
      ram_addr_o        = {18'b0, blit_idx, 2'b00};
      ram_write_data_o  = blit_wdata;
      ram_write_mask_o  = blit_mask;
    end
  end

  assign cpu_read_data_o = ram_read_data_i;
  assign cmd_ready_o     = (state_q == IDLE);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;

endmodule

// File: tb/tb_vram_blitter.sv
// tb_vram_blitter: scoreboard bench for vram_blitter with a 1-cycle RAM model.
// COPY scenarios follow VRAM_BLIT_COPY_EN as the design does.
module tb_vram_blitter;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_cs;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [3:0]  cpu_mask;
  logic        cmd_valid, cmd_ready, cmd_op;
  logic [11:0] cmd_src, cmd_dst;
  logic [12:0] cmd_len;
  logic [31:0] cmd_fill;
  logic        busy, done;
  logic        ram_cs;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_mask;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] mem [0:4095];
  int          checks = 0;
  int          errors = 0;
  int          wr_count = 0;

  always #5 clk = ~clk;

  vram_blitter dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .cpu_chip_select_i (cpu_cs),
    .cpu_addr_i        (cpu_addr),
    .cpu_write_data_i  (cpu_wdata),
    .cpu_write_mask_i  (cpu_mask),
    .cpu_read_data_o   (cpu_rdata),
    .cmd_valid_i       (cmd_valid),
    .cmd_ready_o       (cmd_ready),
    .cmd_op_i          (cmd_op),
    .cmd_src_i         (cmd_src),
    .cmd_dst_i         (cmd_dst),
    .cmd_len_i         (cmd_len),
    .cmd_fill_i        (cmd_fill),
    .busy_o            (busy),
    .done_o            (done),
    .ram_chip_select_o (ram_cs),
    .ram_addr_o        (ram_addr),
    .ram_write_data_o  (ram_wdata),
    .ram_write_mask_o  (ram_mask),
    .ram_read_data_i   (ram_rdata)
  );

  // Video RAM: read-before-write, one cycle of read latency.
  always @(posedge clk) begin
    if (ram_cs) begin
      ram_rdata <= mem[ram_addr[13:2]];
      for (int b = 0; b < 4; b++)
        if (ram_mask[b])
          mem[ram_addr[13:2]][8*b +: 8] = ram_wdata[8*b +: 8];
    end
  end

  // Scoreboard: every blitter write must match the next expected write.
  always @(negedge clk) begin
    wr_t e;
    if (!reset && ram_cs && !cpu_cs && ram_mask != 4'h0) begin
      wr_count++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        if (ram_addr !== e.addr || ram_wdata !== e.data) begin
          errors++;
          $display("FAIL write addr=%h data=%h exp addr=%h data=%h",
                   ram_addr, ram_wdata, e.addr, e.data);
        end
      end
    end
  end

  task automatic push_wr(input logic [11:0] idx, input logic [31:0] d);
    wr_t e;
    e.addr = {18'b0, idx, 2'b00};
    e.data = d;
    exp_q.push_back(e);
  endtask

  // Offers one command for a single cycle; returns #1 into the cycle after accept.
  task automatic send_cmd(input logic op, input logic [11:0] src,
                          input logic [11:0] dst, input logic [12:0] len,
                          input logic [31:0] fill);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_src   = src;
    cmd_dst   = dst;
    cmd_len   = len;
    cmd_fill  = fill;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 || ram_cs !== 1'b0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b ready=%b cs=%b exp 0 0 1 0",
               busy, done, cmd_ready, ram_cs);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || ram_cs !== 1'b0 || ram_mask !== 4'h0) begin
      errors++;
      $display("FAIL post_reset busy=%b ready=%b cs=%b mask=%h exp 0 1 0 0",
               busy, cmd_ready, ram_cs, ram_mask);
    end
  endtask

  task automatic test_fill_basic();
    for (int i = 0; i < 4; i++) push_wr(12'h010 + 12'(i), 32'h0000_0720);
    send_cmd(1'b0, 12'h000, 12'h010, 13'd4, 32'h0000_0720);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if (ram_cs !== (k < 4) || busy !== (k < 4) || done !== (k == 4)) begin
        errors++;
        $display("FAIL fill_basic k=%0d cs=%b busy=%b done=%b exp %b %b %b",
                 k, ram_cs, busy, done, k < 4, k < 4, k == 4);
      end
      @(posedge clk); #1;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL fill_basic_left got=%0d exp=0", exp_q.size());
    end
  endtask

  task automatic test_fill_wrap();
    int done_at;
    done_at = -1;
    push_wr(12'hFFE, 32'hDEAD_BEEF);
    push_wr(12'hFFF, 32'hDEAD_BEEF);
    push_wr(12'h000, 32'hDEAD_BEEF);
    send_cmd(1'b0, 12'h000, 12'hFFE, 13'd3, 32'hDEAD_BEEF);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at != 3) begin
      errors++;
      $display("FAIL wrap_done got=%0d exp=3", done_at);
    end
    checks++;
    if (mem[12'hFFE] !== 32'hDEAD_BEEF || mem[12'hFFF] !== 32'hDEAD_BEEF ||
        mem[0] !== 32'hDEAD_BEEF || mem[12'hFFD] !== 32'h0) begin
      errors++;
      $display("FAIL wrap_mem got=%h %h %h %h exp deadbeef x3 then 0",
               mem[12'hFFE], mem[12'hFFF], mem[0], mem[12'hFFD]);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wrap_left got=%0d exp=0", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fill_stall();
    int base, done_at, ndone;
    done_at = -1;
    ndone   = 0;
    for (int i = 0; i < 8; i++) push_wr(12'h100 + 12'(i), 32'h1234_5678);
    send_cmd(1'b0, 12'h000, 12'h100, 13'd8, 32'h1234_5678);
    base = wr_count;
    for (int k = 0; k < 14; k++) begin
      cpu_cs    = (k >= 2 && k <= 4);
      cpu_addr  = (k == 4) ? 32'h0000_2004 : 32'h0000_2000;
      cpu_wdata = 32'hCAFE_F00D;
      cpu_mask  = (k == 2) ? 4'h3 : 4'h0;
      @(negedge clk);
      if (cpu_cs) begin
        checks++;
        if (ram_cs !== 1'b1 || ram_addr !== cpu_addr ||
            ram_wdata !== cpu_wdata || ram_mask !== cpu_mask) begin
          errors++;
          $display("FAIL cpu_pass k=%0d cs=%b addr=%h data=%h mask=%h exp 1 %h %h %h",
                   k, ram_cs, ram_addr, ram_wdata, ram_mask,
                   cpu_addr, cpu_wdata, cpu_mask);
        end
      end
      if (k == 4) begin
        checks++;
        if (cpu_rdata !== 32'h0000_F00D) begin
          errors++;
          $display("FAIL cpu_rdata got=%h exp=0000f00d", cpu_rdata);
        end
      end
      if (done === 1'b1) begin
        ndone++;
        done_at = k;
      end
      @(posedge clk); #1;
    end
    cpu_cs   = 1'b0;
    cpu_mask = 4'h0;
    checks++;
    if (done_at != 11 || ndone != 1) begin
      errors++;
      $display("FAIL stall_done got=%0d count=%0d exp=11 count=1", done_at, ndone);
    end
    checks++;
    if (wr_count - base != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_writes got=%0d left=%0d exp=8 left=0",
               wr_count - base, exp_q.size());
    end
    checks++;
    if (mem[12'h800] !== 32'h0000_F00D) begin
      errors++;
      $display("FAIL stall_cpu_mem got=%h exp=0000f00d", mem[12'h800]);
    end
  endtask

  task automatic test_reset_mid();
    push_wr(12'h200, 32'h55AA_55AA);
    push_wr(12'h201, 32'h55AA_55AA);
    send_cmd(1'b0, 12'h000, 12'h200, 13'd6, 32'h55AA_55AA);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ram_cs !== 1'b0 || cmd_ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset busy=%b cs=%b ready=%b done=%b exp 0 0 1 0",
               busy, ram_cs, cmd_ready, done);
    end
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || ram_cs !== 1'b0) begin
        errors++;
        $display("FAIL after_reset k=%0d done=%b cs=%b exp 0 0", k, done, ram_cs);
      end
    end
    checks++;
    if (mem[12'h200] !== 32'h55AA_55AA || mem[12'h201] !== 32'h55AA_55AA ||
        mem[12'h202] !== 32'h0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL reset_mem got=%h %h %h left=%0d exp 55aa55aa 55aa55aa 0 left=0",
               mem[12'h200], mem[12'h201], mem[12'h202], exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_len_zero(input logic op);
    int base;
    base = wr_count;
    send_cmd(op, 12'h040, 12'h123, op ? 13'd5 : 13'd0, 32'hFFFF_FFFF);
    if (op) begin
      // COPY with the COPY path compiled out: same as len=0.
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || ram_cs !== 1'b0 || cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero op=%b done=%b busy=%b cs=%b ready=%b exp 1 0 0 1",
               op, done, busy, ram_cs, cmd_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || ram_cs !== 1'b0 || wr_count != base) begin
      errors++;
      $display("FAIL zero_after op=%b done=%b cs=%b writes=%0d exp 0 0 0",
               op, done, ram_cs, wr_count - base);
    end
    @(posedge clk); #1;
  endtask

`ifdef VRAM_BLIT_COPY_EN
  task automatic test_copy();
    mem[12'h050] = 32'hA5A5_A5A5;
    mem[12'h000] = 32'h1111_2222;
    push_wr(12'h000, 32'hA5A5_A5A5);
    send_cmd(1'b1, 12'h050, 12'h000, 13'd1, 32'h0);
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_addr !== 32'h140 || ram_mask !== 4'h0) begin
      errors++;
      $display("FAIL copy_rd cs=%b addr=%h mask=%h exp 1 00000140 0",
               ram_cs, ram_addr, ram_mask);
    end
    @(posedge clk); #1;
    cpu_cs   = 1'b1;
    cpu_addr = 32'h0;
    cpu_mask = 4'h0;
    @(negedge clk);
    checks++;
    if (ram_cs !== 1'b1 || ram_addr !== 32'h0 || ram_mask !== 4'h0) begin
      errors++;
      $display("FAIL copy_cap_cpu cs=%b addr=%h mask=%h exp 1 0 0",
               ram_cs, ram_addr, ram_mask);
    end
    @(posedge clk); #1;
    cpu_cs = 1'b0;
    @(negedge clk);
    checks++;
    if (cpu_rdata !== 32'h1111_2222 || ram_cs !== 1'b1 || ram_mask !== 4'hF) begin
      errors++;
      $display("FAIL copy_wr rdata=%h cs=%b mask=%h exp 11112222 1 f",
               cpu_rdata, ram_cs, ram_mask);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || mem[0] !== 32'hA5A5_A5A5 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL copy_done done=%b mem0=%h left=%0d exp 1 a5a5a5a5 0",
               done, mem[0], exp_q.size());
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_back_to_back();
    int done_at;
    done_at = -1;
    push_wr(12'h300, 32'hAAAA_0001);
    push_wr(12'h301, 32'hAAAA_0001);
    for (int i = 0; i < 3; i++) push_wr(12'h302 + 12'(i), 32'hBBBB_0002);
    @(posedge clk); #1;
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_dst   = 12'h300;
    cmd_len   = 13'd2;
    cmd_fill  = 32'hAAAA_0001;
    @(posedge clk); #1;
    cmd_dst   = 12'h302;
    cmd_len   = 13'd3;
    cmd_fill  = 32'hBBBB_0002;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (cmd_ready !== (k == 2) || done !== (k == 2)) begin
        errors++;
        $display("FAIL b2b k=%0d ready=%b done=%b exp %b %b",
                 k, cmd_ready, done, k == 2, k == 2);
      end
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        done_at = k;
        break;
      end
    end
    checks++;
    if (done_at != 3 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL b2b_second done=%0d left=%0d exp 3 0", done_at, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    reset     = 1'b1;
    cpu_cs    = 1'b0;
    cpu_addr  = 32'h0;
    cpu_wdata = 32'h0;
    cpu_mask  = 4'h0;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_src   = 12'h0;
    cmd_dst   = 12'h0;
    cmd_len   = 13'h0;
    cmd_fill  = 32'h0;
    test_reset();
    test_fill_basic();
    test_fill_wrap();
    test_fill_stall();
    test_reset_mid();
    test_len_zero(1'b0);
`ifdef VRAM_BLIT_COPY_EN
    test_copy();
`else
    test_len_zero(1'b1);
`endif
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
